// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the div/mod execute-stage sequencer.
// Holds operand widths, op_type encodings, FSM state encodings, the latched
// request payload and small decode/select helpers.
package div_ctrl_pkg;

    localparam int unsigned REG_WIDTH        = 32;
    localparam int unsigned DOUBLE_REG_WIDTH = 64;

    // op_type encodings from the decoder
    localparam logic [1:0] DivOpDivW  = 2'b00;
    localparam logic [1:0] DivOpModW  = 2'b01;
    localparam logic [1:0] DivOpDivWU = 2'b10;
    localparam logic [1:0] DivOpModWU = 2'b11;

    // sequencer FSM states
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_BUSY       = 2'd1;
    localparam logic [1:0] ST_HOLD       = 2'd2;
    localparam logic [1:0] ST_FLUSH_WAIT = 2'd3;

    // operation attributes derived from op_type
    typedef struct packed {
        logic is_signed;
        logic sel_rem;
    } div_attr_t;

    // request payload held stable toward the divider for a whole division
    typedef struct packed {
        logic [REG_WIDTH-1:0] op1;
        logic [REG_WIDTH-1:0] op2;
        logic                 is_signed;
        logic                 sel_rem;
    } div_req_t;

    function automatic div_attr_t decode_op(input logic [1:0] op_type);
        div_attr_t attr;
        case (op_type)
            DivOpDivW:  attr = '{is_signed: 1'b1, sel_rem: 1'b0};
            DivOpModW:  attr = '{is_signed: 1'b1, sel_rem: 1'b1};
            DivOpDivWU: attr = '{is_signed: 1'b0, sel_rem: 1'b0};
            DivOpModWU: attr = '{is_signed: 1'b0, sel_rem: 1'b1};
            default:    attr = '{is_signed: 1'b0, sel_rem: 1'b0};
        endcase
        return attr;
    endfunction

    // divider result layout is {remainder, quotient}
    function automatic logic [REG_WIDTH-1:0] select_result(
        input logic                        sel_rem,
        input logic [DOUBLE_REG_WIDTH-1:0] res
    );
        return sel_rem ? res[DOUBLE_REG_WIDTH-1:REG_WIDTH] : res[REG_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/div_ctrl.sv
// Execute-stage sequencer in front of the 32-cycle radix-2 divider.
// Latches operands, drives divider start/cancel/signed, stalls the pipeline
// until the result is captured, holds the result across downstream stalls and
// drains the divider after a flush before allowing a new start.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   flush          pipeline flush, kills the in-flight division
//   ex_stall_i     downstream stall, EX instruction held this cycle
//   op_valid       EX holds a valid div/mod instruction
//   op_type        00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu
//   src1, src2     dividend, divisor
//   div_start      divider start (registered)
//   div_cancel     divider cancel (combinational)
//   div_signed     divider signed_op (registered)
//   div_op1/op2    divider operands (registered, stable until capture)
//   div_result     divider {remainder, quotient}
//   div_done       divider done
//   stall_req      pipeline freeze request (combinational)
//   result_o       selected quotient/remainder (registered)
//   result_valid   result_o valid for the EX instruction (registered)
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_WAIT_CYC = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        ex_stall_i,
    input  logic                        op_valid,
    input  logic [1:0]                  op_type,
    input  logic [REG_WIDTH-1:0]        src1,
    input  logic [REG_WIDTH-1:0]        src2,
    output logic                        div_start,
    output logic                        div_cancel,
    output logic                        div_signed,
    output logic [REG_WIDTH-1:0]        div_op1,
    output logic [REG_WIDTH-1:0]        div_op2,
    input  logic [DOUBLE_REG_WIDTH-1:0] div_result,
    input  logic                        div_done,
    output logic                        stall_req,
    output logic [REG_WIDTH-1:0]        result_o,
    output logic                        result_valid
);

    localparam int unsigned CNT_W = (FLUSH_WAIT_CYC < 2) ? 1 : $clog2(FLUSH_WAIT_CYC + 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_n;
    div_req_t             r_req;
    div_req_t             w_req_n;
    logic                 r_start;
    logic                 w_start_n;
    logic [REG_WIDTH-1:0] r_result;
    logic [REG_WIDTH-1:0] w_result_n;
    logic                 r_result_valid;
    logic                 w_result_valid_n;
    logic [CNT_W-1:0]     r_wait_cnt;
    logic [CNT_W-1:0]     w_wait_cnt_n;
    div_attr_t            w_attr;

    assign w_attr = decode_op(op_type);

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_req          <= '0;
            r_start        <= 1'b0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
            r_wait_cnt     <= '0;
        end else begin
            r_state        <= w_state_n;
            r_req          <= w_req_n;
            r_start        <= w_start_n;
            r_result       <= w_result_n;
            r_result_valid <= w_result_valid_n;
            r_wait_cnt     <= w_wait_cnt_n;
        end
    end

    // next-state and next-output logic
    always_comb begin
        w_state_n        = r_state;
        w_req_n          = r_req;
        w_start_n        = r_start;
        w_result_n       = r_result;
        w_result_valid_n = r_result_valid;
        w_wait_cnt_n     = r_wait_cnt;

        case (r_state)
            ST_IDLE: begin
                if (op_valid && !flush) begin
                    w_req_n.op1       = src1;
                    w_req_n.op2       = src2;
                    w_req_n.is_signed = w_attr.is_signed;
                    w_req_n.sel_rem   = w_attr.sel_rem;
                    w_start_n         = 1'b1;
                    w_state_n         = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // flush wins: a done arriving with the flush is discarded
                if (flush) begin
                    w_start_n    = 1'b0;
                    w_wait_cnt_n = CNT_W'(FLUSH_WAIT_CYC);
                    w_state_n    = ST_FLUSH_WAIT;
                end else if (div_done) begin
                    w_result_n       = select_result(r_req.sel_rem, div_result);
                    w_result_valid_n = 1'b1;
                    w_start_n        = 1'b0;
                    w_state_n        = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    w_result_valid_n = 1'b0;
                    w_wait_cnt_n     = CNT_W'(FLUSH_WAIT_CYC);
                    w_state_n        = ST_FLUSH_WAIT;
                end else if (!ex_stall_i) begin
                    w_result_valid_n = 1'b0;
                    w_state_n        = ST_IDLE;
                end
            end
            ST_FLUSH_WAIT: begin
                // start stays low long enough for the divider to reach idle
                w_start_n = 1'b0;
                if (r_wait_cnt <= CNT_W'(1)) begin
                    w_wait_cnt_n = '0;
                    w_state_n    = ST_IDLE;
                end else begin
                    w_wait_cnt_n = r_wait_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    assign div_cancel = (r_state == ST_BUSY) && flush;

    assign stall_req = ((r_state == ST_IDLE) && op_valid && !flush)
                     || ((r_state == ST_BUSY) && !flush)
                     || ((r_state == ST_FLUSH_WAIT) && op_valid);

    assign div_start    = r_start;
    assign div_signed   = r_req.is_signed;
    assign div_op1      = r_req.op1;
    assign div_op2      = r_req.op2;
    assign result_o     = r_result;
    assign result_valid = r_result_valid;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: a cycle-level divider model stands in for the radix-2
// divider, a scoreboard queue holds expected results, and a negedge monitor
// compares every presented result.
module tb_div_ctrl;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        ex_stall_i;
    logic        op_valid;
    logic [1:0]  op_type;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        div_start;
    logic        div_cancel;
    logic        div_signed;
    logic [31:0] div_op1;
    logic [31:0] div_op2;
    logic [63:0] div_result;
    logic        div_done;
    logic        stall_req;
    logic [31:0] result_o;
    logic        result_valid;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [31:0] exp_q[$];

    div_ctrl #(.FLUSH_WAIT_CYC(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .ex_stall_i   (ex_stall_i),
        .op_valid     (op_valid),
        .op_type      (op_type),
        .src1         (src1),
        .src2         (src2),
        .div_start    (div_start),
        .div_cancel   (div_cancel),
        .div_signed   (div_signed),
        .div_op1      (div_op1),
        .div_op2      (div_op2),
        .div_result   (div_result),
        .div_done     (div_done),
        .stall_req    (stall_req),
        .result_o     (result_o),
        .result_valid (result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- divider model ----------------
    // Samples start only when idle and not cancelled; done after 34 edges
    // (2 for a zero divisor); reads operands live at completion; holds done
    // until start drops; result bus carries junk whenever done is low.
    function automatic logic [63:0] dv_arith(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint x;
        longint y;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        x = sgn ? longint'($signed(a)) : longint'(a);
        y = sgn ? longint'($signed(b)) : longint'(b);
        q = x / y;
        r = x - q * y;
        return {r[31:0], q[31:0]};
    endfunction

    int          dv_state;
    int          dv_cnt;
    logic        dv_zero;

    always @(posedge clk) begin
        if (rst) begin
            dv_state   <= 0;
            dv_cnt     <= 0;
            dv_zero    <= 1'b0;
            div_done   <= 1'b0;
            div_result <= 64'd0;
        end else begin
            if (dv_state != 2) div_result <= {$urandom, $urandom};
            case (dv_state)
                0: if (div_start && !div_cancel) begin
                    dv_state <= 1;
                    dv_cnt   <= 0;
                    dv_zero  <= (div_op2 == 32'd0);
                end
                1: begin
                    if (div_cancel) dv_state <= 0;
                    else if (dv_cnt == (dv_zero ? 1 : 33)) begin
                        dv_state   <= 2;
                        div_done   <= 1'b1;
                        div_result <= dv_arith(div_signed, div_op1, div_op2);
                    end else dv_cnt <= dv_cnt + 1;
                end
                default: begin
                    if (div_cancel || !div_start) begin
                        dv_state <= 0;
                        div_done <= 1'b0;
                    end
                end
            endcase
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint x;
        longint y;
        longint v;
        bit     is_signed;
        bit     want_rem;
        is_signed = (op == 2'b00) || (op == 2'b01);
        want_rem  = (op == 2'b01) || (op == 2'b11);
        if (b == 32'd0) return 32'd0;
        x = is_signed ? longint'($signed(a)) : longint'({32'd0, a});
        y = is_signed ? longint'($signed(b)) : longint'({32'd0, b});
        v = want_rem ? (x % y) : (x / y);
        return v[31:0];
    endfunction

    // ---------------- monitor ----------------
    logic        prev_rv;
    logic        prev_start;
    logic [31:0] held_res;
    int          fall_cyc;
    bit          have_fall;
    logic [31:0] e;

    always @(negedge clk) begin
        if (rst) begin
            prev_rv    = 1'b0;
            prev_start = 1'b0;
            have_fall  = 0;
        end else begin
            if (result_valid && !prev_rv) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(result_o), 64'hDEAD_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    check("result", 64'(result_o), 64'(e));
                end
                held_res = result_o;
            end else if (result_valid && prev_rv) begin
                check("result_hold_stable", 64'(result_o), 64'(held_res));
            end
            if (div_start && !prev_start && have_fall)
                check("start_gap_ge2", 64'(cyc - fall_cyc >= 2), 64'd1);
            if (!div_start && prev_start) begin
                fall_cyc  = cyc;
                have_fall = 1;
            end
            prev_rv    = result_valid;
            prev_start = div_start;
        end
    end

    // ---------------- stimulus ----------------
    // Presents one instruction in EX until it leaves (result accepted) or is
    // flushed at relative cycle flush_cyc. exp_lat is the expected relative
    // cycle of the first result_valid.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int flush_cyc, input int stall_cyc, input int exp_lat);
        int  rv_cyc;
        int  rv_seen;
        int  held;
        int  cancels;
        bit  stall_bad;
        bit  finished;
        bit  rv_now;
        op_valid   = 1'b1;
        op_type    = op;
        src1       = a;
        src2       = b;
        rv_cyc     = -1;
        rv_seen    = 0;
        held       = 0;
        cancels    = 0;
        stall_bad  = 0;
        finished   = 0;
        if (flush_cyc < 0) exp_q.push_back(ref_result(op, a, b));
        for (int k = 0; k < 200 && !finished; k++) begin
            flush      = (k == flush_cyc);
            ex_stall_i = result_valid && (held < stall_cyc);
            @(negedge clk);
            rv_now = result_valid;
            if (div_cancel) cancels++;
            if (rv_now) begin
                rv_seen++;
                if (rv_cyc < 0) rv_cyc = k;
            end
            if (flush_cyc < 0 && k <= exp_lat && (stall_req !== (k < exp_lat))) stall_bad = 1;
            if (ex_stall_i) held++;
            @(posedge clk);
            #1;
            if ((k == flush_cyc) || (rv_now && !ex_stall_i)) finished = 1;
        end
        op_valid   = 1'b0;
        flush      = 1'b0;
        ex_stall_i = 1'b0;
        check("completes_in_budget", 64'(finished), 64'd1);
        if (flush_cyc < 0) begin
            check("latency", 64'(rv_cyc), 64'(exp_lat));
            check("stall_window", 64'(stall_bad), 64'd0);
            check("valid_cycles", 64'(rv_seen), 64'(stall_cyc + 1));
            check("no_cancel", 64'(cancels), 64'd0);
        end else begin
            check("cancel_pulses", 64'(cancels), 64'd1);
            check("no_result_on_flush", 64'(rv_seen), 64'd0);
        end
    endtask

    task automatic check_reset_state();
        check("rst_div_start", 64'(div_start), 64'd0);
        check("rst_div_signed", 64'(div_signed), 64'd0);
        check("rst_div_op1", 64'(div_op1), 64'd0);
        check("rst_div_op2", 64'(div_op2), 64'd0);
        check("rst_result_o", 64'(result_o), 64'd0);
        check("rst_result_valid", 64'(result_valid), 64'd0);
        check("rst_div_cancel", 64'(div_cancel), 64'd0);
        check("rst_stall_req", 64'(stall_req), 64'd0);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        int          r_fl;
        int          r_lat;
        bit          after_flush;

        rst        = 1'b1;
        flush      = 1'b0;
        ex_stall_i = 1'b0;
        op_valid   = 1'b0;
        op_type    = 2'b00;
        src1       = 32'd0;
        src2       = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // directed cases
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2,   -1, 0, 37);
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2,   -1, 0, 37);
        run_op(2'b11, 32'd100,       32'd7,   -1, 5, 37);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,   -1, 0, 37);
        run_op(2'b00, 32'd1234,      32'd0,   -1, 0, 5);
        run_op(2'b00, 32'd50,        32'd3,   10, 0, 0);
        run_op(2'b00, 32'd20,        32'd4,   -1, 0, 39);
        run_op(2'b00, 32'd77,        32'd0,    2, 0, 0);
        run_op(2'b00, 32'd20,        32'd4,   -1, 0, 39);
        run_op(2'b10, 32'd9,         32'd3,   -1, 0, 37);
        run_op(2'b10, 32'd10,        32'd4,   -1, 0, 37);

        // reset in the middle of a division
        op_valid = 1'b1;
        op_type  = 2'b01;
        src1     = 32'd1000;
        src2     = 32'd13;
        repeat (10) @(posedge clk);
        #1;
        rst      = 1'b1;
        op_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_op(2'b01, 32'd1000, 32'd13, -1, 1, 37);

        // randomized operations, occasionally flushed
        after_flush = 0;
        for (int n = 0; n < 12; n++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            case ($urandom_range(0, 3))
                0:       r_b = 32'd0;
                1:       r_b = 32'($urandom_range(1, 15));
                2:       r_b = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
                default: r_b = $urandom;
            endcase
            r_lat = ((r_b == 32'd0) ? 5 : 37) + (after_flush ? 2 : 0);
            r_fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(1 + (after_flush ? 2 : 0), r_lat - 1) : -1;
            run_op(r_op, r_a, r_b, r_fl, (r_fl < 0) ? $urandom_range(0, 3) : 0, r_lat);
            after_flush = (r_fl >= 0);
        end

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("final_idle_stall", 64'(stall_req), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
